// File: rtl/wind_apply.sv
// wind_apply: turns the wind controller's 7-bit code into a signed drift and
// applies it to a projectile's x-velocity once per frame tick while a shot is
// in flight. It also provides registered wind direction and magnitude for the HUD.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   wind        in   wind code 0..100 (50 = calm); values above 100 clamp to 100
//   shot_start  in   pulse: latch wind and vx_init, enter flight
//   vx_init     in   signed initial x-velocity, sampled on shot_start
//   frame_tick  in   pulse, once per video frame
//   shot_end    in   pulse: projectile landed or left the screen
//   shot_active out  high while in flight
//   vx          out  signed current x-velocity (registered)
//   vx_step     out  pulse, asserted with the vx value that wind just changed
//   hud_dir     out  1 = wind toward +x
//   hud_mag     out  |clamped wind - 50|, 0..50
module wind_apply #(
  parameter int unsigned VX_W    = 11,
  parameter int          VX_MAX  = 255,
  parameter int          ACC_DIV = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             wind,
  input  logic                   shot_start,
  input  logic signed [VX_W-1:0] vx_init,
  input  logic                   frame_tick,
  input  logic                   shot_end,
  output logic                   shot_active,
  output logic signed [VX_W-1:0] vx,
  output logic                   vx_step,
  output logic                   hud_dir,
  output logic [5:0]             hud_mag
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_FLIGHT = 1'b1;

  // |acc| < 511 and |w| <= 50, so the sum always fits in 11 signed bits.
  localparam int unsigned ACC_W = 11;

  localparam logic signed [VX_W-1:0]  L_VX_MAX = VX_W'(VX_MAX);
  localparam logic signed [VX_W-1:0]  L_VX_MIN = -L_VX_MAX;
  localparam logic signed [VX_W-1:0]  L_VX_ONE = VX_W'(1);
  localparam logic signed [ACC_W-1:0] L_DIV    = ACC_W'(ACC_DIV);
  localparam logic signed [ACC_W-1:0] L_NDIV   = -L_DIV;

  logic                    r_state;
  logic signed [VX_W-1:0]  r_vx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [6:0]       r_w;
  logic                    r_step;
  logic                    r_hud_dir;
  logic [5:0]              r_hud_mag;

  logic [6:0]              w_wind_c;
  logic signed [7:0]       w_drift8;
  logic signed [6:0]       w_drift;
  logic [5:0]              w_mag;
  logic signed [VX_W-1:0]  w_vx_init_sat;
  logic signed [ACC_W-1:0] w_sum;

  logic                    w_state_d;
  logic signed [VX_W-1:0]  w_vx_d;
  logic signed [ACC_W-1:0] w_acc_d;
  logic signed [6:0]       w_w_d;
  logic                    w_step_d;

  assign w_wind_c = (wind > 7'd100) ? 7'd100 : wind;
  // Computed in 8 bits because codes above 63 would read as negative in 7.
  assign w_drift8 = $signed({1'b0, w_wind_c}) - 8'sd50;
  assign w_drift  = w_drift8[6:0];
  assign w_mag    = (w_wind_c > 7'd50) ? 6'(w_wind_c - 7'd50) : 6'(7'd50 - w_wind_c);

  assign w_vx_init_sat = (vx_init > L_VX_MAX) ? L_VX_MAX :
                         (vx_init < L_VX_MIN) ? L_VX_MIN : vx_init;

  assign w_sum = r_acc + $signed({{(ACC_W - 7){r_w[6]}}, r_w});

  always_comb begin
    w_state_d = r_state;
    w_vx_d    = r_vx;
    w_acc_d   = r_acc;
    w_w_d     = r_w;
    w_step_d  = 1'b0;
    if (shot_start) begin
      // Fire or re-fire wins over shot_end and frame_tick.
      w_state_d = ST_FLIGHT;
      w_vx_d    = w_vx_init_sat;
      w_acc_d   = '0;
      w_w_d     = w_drift;
    end else if (r_state == ST_FLIGHT) begin
      if (shot_end) begin
        w_state_d = ST_IDLE;
        w_acc_d   = '0;
      end else if (frame_tick) begin
        if (w_sum >= L_DIV) begin
          // The accumulator drains even when vx is pinned at the limit.
          w_acc_d = w_sum - L_DIV;
          if (r_vx != L_VX_MAX) begin
            w_vx_d   = r_vx + L_VX_ONE;
            w_step_d = 1'b1;
          end
        end else if (w_sum <= L_NDIV) begin
          w_acc_d = w_sum + L_DIV;
          if (r_vx != L_VX_MIN) begin
            w_vx_d   = r_vx - L_VX_ONE;
            w_step_d = 1'b1;
          end
        end else begin
          w_acc_d = w_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vx      <= '0;
      r_acc     <= '0;
      r_w       <= '0;
      r_step    <= 1'b0;
      r_hud_dir <= 1'b0;
      r_hud_mag <= '0;
    end else begin
      r_state   <= w_state_d;
      r_vx      <= w_vx_d;
      r_acc     <= w_acc_d;
      r_w       <= w_w_d;
      r_step    <= w_step_d;
      // HUD follows the live wind, not the latched drift.
      r_hud_dir <= (w_wind_c > 7'd50);
      r_hud_mag <= w_mag;
    end
  end

  assign shot_active = (r_state == ST_FLIGHT);
  assign vx          = r_vx;
  assign vx_step     = r_step;
  assign hud_dir     = r_hud_dir;
  assign hud_mag     = r_hud_mag;

endmodule
